// File: rtl/hlsm_driver_pkg.sv
// hlsm_driver_pkg
// Shared definitions for the HLS accelerator driver: operand bus layout,
// response status codes, controller state encoding and the default Done
// timeout.
package hlsm_driver_pkg;

  // Operand bus: eight signed bytes a..h, then the divisor num on top.
  localparam int OPND_W  = 8;
  localparam int N_OPNDS = 8;
  localparam int NUM_LSB = N_OPNDS * OPND_W;
  localparam int DATA_W  = NUM_LSB + OPND_W;

  localparam int DEFAULT_TIMEOUT_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_DIV0    = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  // LSB position of operand idx (0 = a ... 7 = h) on the operand bus.
  function automatic int opnd_lsb(input int idx);
    return idx * OPND_W;
  endfunction

endpackage

// File: rtl/hlsm_driver.sv
// hlsm_driver
// Host-side driver for an HLS averaging accelerator. Accepts one job at a
// time from the host, launches the accelerator, waits for Done (with a
// timeout that resets the accelerator) and returns the result to the host.
//
// Ports
//   Clk         rising-edge clock
//   Rst         synchronous active-low reset
//   req_valid   host offers a job           req_ready  driver can take it
//   req_data    operands a..h + num (72b)
//   Start       one-cycle launch pulse      op_data    operand bus to accel
//   Done        accelerator done level      avg        accelerator result
//   hls_rst     active-high accelerator reset pulse
//   rsp_valid   response available          rsp_ready  host consumes it
//   rsp_avg     signed result               rsp_status 00 ok/01 timeout/10 div0
//   job_cnt     responses consumed, wraps
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a job; captures operands on req_valid
// LAUNCH | Start pulse is high, timeout counter cleared
// WAIT   | waiting for Done (ignored in the first cycle) or timeout
// RESP   | response held on rsp_* until the host takes it
module hlsm_driver
  import hlsm_driver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              Start,
  output logic [DATA_W-1:0] op_data,
  input  logic              Done,
  input  logic [7:0]        avg,
  output logic              hls_rst,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_avg,
  output logic [1:0]        rsp_status,
  output logic [7:0]        job_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_op;
  logic              r_start;
  logic              r_hls_rst;
  logic [7:0]        r_rsp_avg;
  status_e           r_status;
  logic [7:0]        r_job_cnt;

  logic w_num_zero;
  logic w_done_ok;
  logic w_timeout;

  assign w_num_zero = (req_data[NUM_LSB +: OPND_W] == '0);

  // r_cnt is 0 in the first WAIT cycle; Done seen then belongs to the
  // previous job, since the accelerator holds it until it sees Start.
  assign w_done_ok = (r_cnt != '0) && Done;

  // WAIT cycle k after Start carries r_cnt = k-1. Leaving WAIT when
  // r_cnt + 2 reaches the limit places the hls_rst pulse exactly
  // TIMEOUT_CYCLES cycles after Start.
  assign w_timeout = (({1'b0, r_cnt} + (CNT_W+1)'(2)) >= TO_LIM);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_start   <= 1'b0;
      r_hls_rst <= 1'b1;
      r_rsp_avg <= '0;
      r_status  <= ST_OK;
      r_job_cnt <= '0;
    end else begin
      r_start   <= 1'b0;
      r_hls_rst <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op <= req_data;
            if (w_num_zero) begin
              r_rsp_avg <= '0;
              r_status  <= ST_DIV0;
              r_state   <= S_RESP;
            end else begin
              r_start <= 1'b1;
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done_ok) begin
            r_rsp_avg <= avg;
            r_status  <= ST_OK;
            r_state   <= S_RESP;
          end else if (w_timeout) begin
            r_hls_rst <= 1'b1;
            r_rsp_avg <= '0;
            r_status  <= ST_TIMEOUT;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_job_cnt <= r_job_cnt + 8'd1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign Start      = r_start;
  assign hls_rst    = r_hls_rst;
  assign op_data    = r_op;
  assign rsp_avg    = r_rsp_avg;
  assign rsp_status = r_status;
  assign job_cnt    = r_job_cnt;

endmodule

// File: tb/tb_hlsm_driver.sv
module tb_hlsm_driver;
  import hlsm_driver_pkg::*;

  localparam int T    = 32;
  localparam int NONE = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [71:0] req_data = '0;
  logic        rsp_ready = 1'b0;
  logic        inj_done = 1'b0;
  logic        acc_en = 1'b1;
  logic        acc_done = 1'b0;
  logic [7:0]  acc_avg = '0;
  logic        w_done;

  logic        req_ready, Start, hls_rst, rsp_valid;
  logic [71:0] op_data;
  logic [7:0]  rsp_avg, job_cnt;
  logic [1:0]  rsp_status;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign w_done = acc_done | inj_done;

  hlsm_driver #(.TIMEOUT_CYCLES(T)) dut (
    .Clk(clk), .Rst(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .Start(Start), .op_data(op_data), .Done(w_done), .avg(acc_avg),
    .hls_rst(hls_rst), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_avg(rsp_avg), .rsp_status(rsp_status), .job_cnt(job_cnt)
  );

  task automatic ck(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [71:0] pack(input logic [7:0] a, b, c, d, e, f, g, h, num);
    return {num, h, g, f, e, d, c, b, a};
  endfunction

  // Accelerator: truncating signed mean of a..h by num.
  function automatic logic [7:0] ref_avg(input logic [71:0] d);
    int s;
    int n;
    s = 0;
    for (int i = 0; i < N_OPNDS; i++) s += int'($signed(d[opnd_lsb(i) +: 8]));
    n = int'($signed(d[NUM_LSB +: 8]));
    if (n == 0) return 8'h00;
    return 8'(s / n);
  endfunction

  // Accelerator stub: Done rises 12 cycles after the Start cycle and stays
  // high until the cycle after the next Start (so a stale Done is visible in
  // the first WAIT cycle of the following job).
  int          acc_phase = 0;
  logic [71:0] acc_ops = '0;
  always @(posedge clk) begin
    if (hls_rst) begin
      acc_phase <= 0;
      acc_done  <= 1'b0;
    end else if (Start) begin
      acc_phase <= 1;
      acc_ops   <= op_data;
    end else if (acc_phase > 0) begin
      if (acc_phase == 1) acc_done <= 1'b0;
      if (acc_phase == 11) begin
        acc_done  <= acc_en;
        acc_avg   <= ref_avg(acc_ops);
        acc_phase <= 0;
      end else begin
        acc_phase <= acc_phase + 1;
      end
    end
  end

  // Cycle index, stable between posedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Timeline model: a job is described by its acceptance cycle and the
  // cycle its response starts; every output follows from those times.
  bit          m_init = 0;
  bit          m_job = 0;
  bit          m_num0 = 0;
  int          m_acc = 0;
  int          m_resp_start = NONE;
  int          m_hls_at = -10;
  logic [7:0]  m_avg = '0;
  logic [1:0]  m_st = '0;
  logic [7:0]  m_cnt = '0;
  logic [71:0] m_ops = '0;
  bit          e_rv;
  int          lastw;

  int last_start = -1;
  int n_start = 0;
  int last_hls = -1;
  int acc_cyc = -1;

  always @(negedge clk) begin
    if (m_init) begin
      e_rv = m_job && (m_resp_start != NONE) && (cyc >= m_resp_start);
      ck("req_ready", req_ready, !m_job);
      ck("start", Start, m_job && !m_num0 && (cyc == m_acc + 1));
      ck("hls_rst", hls_rst, cyc == m_hls_at);
      ck("start_hls_excl", Start & hls_rst, 1'b0);
      ck("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
        ck("rsp_avg", rsp_avg, m_avg);
        ck("rsp_status", rsp_status, m_st);
      end
      ck("job_cnt", job_cnt, m_cnt);
      ck("op_data", op_data, m_ops);
    end

    if (Start) begin
      n_start++;
      last_start = cyc;
    end
    if (hls_rst) last_hls = cyc;
    if (req_valid && req_ready) acc_cyc = cyc;

    if (!rst_n) begin
      m_init = 1;
      m_job = 0;
      m_resp_start = NONE;
      m_cnt = '0;
      m_ops = '0;
      m_hls_at = cyc + 1;
    end else if (m_init) begin
      if (!m_job) begin
        if (req_valid) begin
          m_job = 1;
          m_acc = cyc;
          m_ops = req_data;
          m_num0 = (req_data[71:64] == 8'd0);
          if (m_num0) begin
            m_resp_start = cyc + 1;
            m_avg = '0;
            m_st = 2'b10;
          end else begin
            m_resp_start = NONE;
          end
        end
      end else if (m_resp_start == NONE) begin
        lastw = (T > 2) ? m_acc + T : m_acc + 2;
        if (cyc >= m_acc + 3 && cyc <= m_acc + T && w_done) begin
          m_resp_start = cyc + 1;
          m_avg = acc_avg;
          m_st = 2'b00;
        end else if (cyc >= lastw) begin
          m_resp_start = cyc + 1;
          m_avg = '0;
          m_st = 2'b01;
          m_hls_at = cyc + 1;
        end
      end else if (cyc >= m_resp_start && rsp_ready) begin
        m_job = 0;
        m_cnt = m_cnt + 8'd1;
      end
    end
  end

  task automatic send(input logic [71:0] d);
    req_data  = d;
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    ck("accept_wait", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic consume(input int hold, output logic [7:0] a, output logic [1:0] s,
                         output int lat_start, output int lat_acc);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    ck("rsp_wait", rsp_valid, 1'b1);
    a = rsp_avg;
    s = rsp_status;
    lat_start = cyc - last_start;
    lat_acc = cyc - acc_cyc;
    repeat (hold) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  logic [7:0] g_avg;
  logic [1:0] g_st;
  int g_lat, g_lat_acc, n0, rv_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    ck("rst_req_ready", req_ready, 1'b1);
    ck("rst_hls_rst", hls_rst, 1'b1);
    ck("rst_start", Start, 1'b0);
    ck("rst_rsp_valid", rsp_valid, 1'b0);
    ck("rst_job_cnt", job_cnt, 8'd0);
    ck("rst_op_data", op_data, 72'd0);
    ck("rst_rsp_avg", rsp_avg, 8'd0);
    ck("rst_rsp_status", rsp_status, 2'b00);
    @(posedge clk); #1;

    // Job 1 (1..8 / 4), then job 2 (-10 x8 / 8) offered while job 1's
    // response is held for 5 cycles; job 2 sees job 1's stale Done.
    n0 = n_start;
    send(pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd4));
    fork
      consume(5, g_avg, g_st, g_lat, g_lat_acc);
      send(pack(8'hF6, 8'hF6, 8'hF6, 8'hF6, 8'hF6, 8'hF6, 8'hF6, 8'hF6, 8'd8));
    join
    ck("job1_avg", g_avg, 8'd9);
    ck("job1_status", g_st, 2'b00);
    ck("job1_latency", g_lat, 13);
    ck("job1_cnt", job_cnt, 8'd1);
    consume(2, g_avg, g_st, g_lat, g_lat_acc);
    ck("job2_avg", g_avg, 8'hF6);
    ck("job2_status", g_st, 2'b00);
    ck("job2_no_early_done", g_lat, 13);
    ck("job12_starts", n_start - n0, 2);
    ck("job2_cnt", job_cnt, 8'd2);

    // Divide by zero: no Start, response the cycle after acceptance.
    n0 = n_start;
    send(pack(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd0));
    consume(1, g_avg, g_st, g_lat, g_lat_acc);
    ck("div0_avg", g_avg, 8'd0);
    ck("div0_status", g_st, 2'b10);
    ck("div0_latency", g_lat_acc, 1);
    ck("div0_no_start", n_start - n0, 0);

    // Accelerator never completes: timeout 32 cycles after Start.
    acc_en = 1'b0;
    send(pack(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2));
    consume(3, g_avg, g_st, g_lat, g_lat_acc);
    ck("to_status", g_st, 2'b01);
    ck("to_avg", g_avg, 8'd0);
    ck("to_hls_delay", last_hls - last_start, 32);
    acc_en = 1'b1;

    // Normal job after a timeout: (4*100 - 4*50) / 3 = 66.
    send(pack(8'd100, 8'd100, 8'd100, 8'd100, 8'hCE, 8'hCE, 8'hCE, 8'hCE, 8'd3));
    consume(1, g_avg, g_st, g_lat, g_lat_acc);
    ck("post_to_avg", g_avg, 8'h42);
    ck("post_to_status", g_st, 2'b00);
    ck("post_to_cnt", job_cnt, 8'd5);

    // Done while idle must be ignored.
    inj_done = 1'b1;
    repeat (4) @(posedge clk);
    #1 inj_done = 1'b0;
    @(negedge clk);
    ck("idle_done_ignored", rsp_valid, 1'b0);
    @(posedge clk); #1;

    // Reset in WAIT, Done arriving afterwards: job abandoned.
    send(pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd4));
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    ck("midrst_req_ready", req_ready, 1'b1);
    ck("midrst_job_cnt", job_cnt, 8'd0);
    ck("midrst_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #1 inj_done = 1'b1;
    rv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
    end
    ck("midrst_no_rsp", rv_seen, 0);
    @(posedge clk);
    #1 inj_done = 1'b0;

    // 256 jobs: job_cnt wraps 255 -> 0.
    for (int i = 0; i < 256; i++) begin
      send(pack(8'(i), 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'(i * 3), 8'd0));
      consume(1 + (i % 3), g_avg, g_st, g_lat, g_lat_acc);
      if (i == 254) ck("wrap_255", job_cnt, 8'd255);
    end
    ck("wrap_0", job_cnt, 8'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
